rgb_pwm_out: RTL and testbench



---
 rtl/rgb_pwm_out.sv | 99 +++++++++
 tb/tb_rgb_pwm_out.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_pwm_out.sv
// rgb_pwm_out: double-buffered multi-channel PWM driver for the board's RGB LED.
// A duty set is accepted through a valid/ready handshake into a shadow register and
// promoted to the active set only at a period wrap, so a period never glitches.
module rgb_pwm_out #(
  parameter int PWM_INTERVAL = 1200,
  parameter int NUM_CH       = 3,
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter int W            = $clog2(PWM_INTERVAL)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_CH*W-1:0] duty_in,
  input  logic                duty_valid,
  output logic                duty_ready,
  output logic [NUM_CH-1:0]   pwm_out,
  output logic                period_start
);

  // Last count value of a period; the edge that sees it is the wrap edge.
  localparam logic [W-1:0]      LAST_COUNT = W'(PWM_INTERVAL - 1);
  // One bit wider than the counter so the clamp limit always fits.
  localparam logic [W:0]        DUTY_LIMIT = (W+1)'(PWM_INTERVAL);
  localparam logic [NUM_CH-1:0] OFF_LEVEL  = {NUM_CH{ACTIVE_LOW}};

  logic [W-1:0]        count_q, count_d;
  logic [NUM_CH*W-1:0] active_q, active_d;
  logic [NUM_CH*W-1:0] shadow_q, shadow_d;
  logic                pending_q, pending_d;
  logic [NUM_CH-1:0]   pwm_q, pwm_d;
  logic                period_start_q, period_start_d;

  logic                wrap;
  logic                accept;
  logic [W:0]          eff [NUM_CH];

  // Shadow register is free whenever nothing is waiting for the next wrap.
  assign duty_ready   = !pending_q;
  assign accept       = duty_valid && duty_ready;
  assign pwm_out      = pwm_q;
  assign period_start = period_start_q;

  // Next-state logic: period counter, handshake/double buffer, output compare.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    count_d        = count_q;
    active_d       = active_q;
    shadow_d       = shadow_q;
    pending_d      = pending_q;
    pwm_d          = OFF_LEVEL;
    period_start_d = 1'b0;
    wrap           = (count_q == LAST_COUNT);

    count_d = wrap ? '0 : count_q + 1'b1;

    // Promotion needs pending=1 and acceptance needs pending=0, so the two never
    // collide; a value accepted on the wrap edge waits for the following wrap.
    if (wrap && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (accept) begin
      shadow_d  = duty_in;
      pending_d = 1'b1;
    end

    // Duty values above the interval saturate to "on for the whole period".
    for (int i = 0; i < NUM_CH; i++) begin
      eff[i]   = ({1'b0, active_q[i*W +: W]} > DUTY_LIMIT) ? DUTY_LIMIT
                                                           : {1'b0, active_q[i*W +: W]};
      pwm_d[i] = ({1'b0, count_q} < eff[i]) ^ ACTIVE_LOW;
    end

    period_start_d = (count_q == '0);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop updates from pre-edge values.
    if (!rst_n) begin
      count_q        <= '0;
      // NOTE: the duty banks are small flop registers, not RAM, and must come up at
      // zero duty, so they take the reset like any other state.
      active_q       <= '0;
      shadow_q       <= '0;
      pending_q      <= 1'b0;
      pwm_q          <= OFF_LEVEL;
      period_start_q <= 1'b0;
    end else begin
      count_q        <= count_d;
      active_q       <= active_d;
      shadow_q       <= shadow_d;
      pending_q      <= pending_d;
      pwm_q          <= pwm_d;
      period_start_q <= period_start_d;
    end
  end

endmodule

// File: tb/tb_rgb_pwm_out.sv
// Testbench for rgb_pwm_out: two instances (active-low and active-high) share one
// stimulus stream; a period-level model predicts every output on every cycle, and
// directed scenarios pin the model with hand-computed on-cycle counts.
module tb_rgb_pwm_out;

  localparam int PI  = 10;
  localparam int NCH = 3;
  localparam int W   = $clog2(PI);

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NCH*W-1:0]     duty_in = '0;
  logic                 duty_valid = 1'b0;
  logic                 ready_l, ready_h;
  logic [NCH-1:0]       pwm_l, pwm_h;
  logic                 ps_l, ps_h;

  always #5 clk = ~clk;

  rgb_pwm_out #(.PWM_INTERVAL(PI), .NUM_CH(NCH), .ACTIVE_LOW(1'b1)) dut_low (
    .clk(clk), .rst_n(rst_n), .duty_in(duty_in), .duty_valid(duty_valid),
    .duty_ready(ready_l), .pwm_out(pwm_l), .period_start(ps_l));

  rgb_pwm_out #(.PWM_INTERVAL(PI), .NUM_CH(NCH), .ACTIVE_LOW(1'b0)) dut_high (
    .clk(clk), .rst_n(rst_n), .duty_in(duty_in), .duty_valid(duty_valid),
    .duty_ready(ready_h), .pwm_out(pwm_h), .period_start(ps_h));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- Model ----------------
  // Each accepted duty set is recorded with the first output period (counted from
  // reset release) in which it governs the waveform.
  typedef struct {
    int               eff_period;
    logic [NCH*W-1:0] val;
  } acc_t;

  acc_t acc_q[$];
  int   k = -1;       // index of last edge since reset release (edge 0 = first released)
  bit   in_rst = 1'b0;
  bit   started = 1'b0;

  // Ready before edge e: every earlier acceptance has already become active.
  function automatic bit model_ready(input int e);
    foreach (acc_q[j]) if (e < PI * acc_q[j].eff_period) return 1'b0;
    return 1'b1;
  endfunction

  // "On" state of each channel for the output shown after edge e.
  function automatic logic [NCH-1:0] model_on(input int e);
    int               q   = e / PI;
    int               pos = e % PI;
    logic [NCH*W-1:0] d   = '0;
    logic [NCH-1:0]   on  = '0;
    foreach (acc_q[j]) if (acc_q[j].eff_period <= q) d = acc_q[j].val;
    for (int i = 0; i < NCH; i++) begin
      int dv = int'(d[i*W +: W]);
      if (dv > PI) dv = PI;
      on[i] = (pos < dv);
    end
    return on;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      acc_q.delete();
      in_rst  = 1'b1;
      started = 1'b1;
      k       = -1;
    end else if (started) begin
      k++;
      in_rst = 1'b0;
      if (duty_valid && model_ready(k)) begin
        acc_t a;
        a.eff_period = k / PI + ((k % PI == PI - 1) ? 2 : 1);
        a.val        = duty_in;
        acc_q.push_back(a);
      end
    end
  end

  // Single compare process: every cycle once the first reset edge has been seen.
  always @(negedge clk) begin
    if (started) begin
      logic [NCH-1:0] on;
      logic [NCH-1:0] exp_l, exp_h;
      logic           exp_ps, exp_rdy;
      if (in_rst) begin
        exp_l = '1; exp_h = '0; exp_ps = 1'b0; exp_rdy = 1'b1;
      end else begin
        on      = model_on(k);
        exp_l   = ~on;
        exp_h   = on;
        exp_ps  = (k % PI == 0);
        exp_rdy = model_ready(k + 1);
      end
      check("model_pwm_low",   32'(pwm_l),   32'(exp_l));
      check("model_pwm_high",  32'(pwm_h),   32'(exp_h));
      check("model_ps_low",    32'(ps_l),    32'(exp_ps));
      check("model_ps_high",   32'(ps_h),    32'(exp_ps));
      check("model_ready_low", 32'(ready_l), 32'(exp_rdy));
      check("model_ready_high",32'(ready_h), 32'(exp_rdy));
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] r, input logic [W-1:0] g, input logic [W-1:0] b);
    duty_in    = {b, g, r};
    duty_valid = 1'b1;
    tick();
    duty_valid = 1'b0;
  endtask

  // Wait for the next period_start, then count active-low lows / active-high highs
  // over one full period and compare against hand-computed duties.
  task automatic measure(input string tag, input int er, input int eg, input int eb);
    int lows[NCH];
    int highs[NCH];
    int exp_n[NCH];
    bit found = 1'b0;
    exp_n[0] = er; exp_n[1] = eg; exp_n[2] = eb;
    for (int i = 0; i < NCH; i++) begin lows[i] = 0; highs[i] = 0; end
    for (int n = 0; n < 3 * PI; n++) begin
      @(negedge clk);
      if (ps_l) begin found = 1'b1; break; end
    end
    check({tag, "_start_seen"}, 32'(found), 32'd1);
    if (found) begin
      for (int c = 0; c < PI; c++) begin
        if (c > 0) @(negedge clk);
        for (int i = 0; i < NCH; i++) begin
          if (pwm_l[i] == 1'b0) lows[i]++;
          if (pwm_h[i] == 1'b1) highs[i]++;
        end
      end
      for (int i = 0; i < NCH; i++) begin
        check($sformatf("%s_low_ch%0d", tag, i),  32'(lows[i]),  32'(exp_n[i]));
        check($sformatf("%s_high_ch%0d", tag, i), 32'(highs[i]), 32'(exp_n[i]));
      end
    end
  endtask

  // ---------------- Directed scenarios ----------------
  initial begin
    bit got;

    // Reset held for 3 cycles.
    repeat (3) tick();
    @(negedge clk);
    check("rst_pwm_low",  32'(pwm_l),   32'h7);
    check("rst_pwm_high", 32'(pwm_h),   32'h0);
    check("rst_ps",       32'(ps_l),    32'h0);
    check("rst_ready",    32'(ready_l), 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    measure("idle0", 0, 0, 0);
    measure("idle1", 0, 0, 0);

    // Basic duty set sent mid-period.
    repeat (3) tick();
    send(4'd3, 4'd7, 4'd0);
    @(negedge clk);
    check("busy_after_send", 32'(ready_l), 32'h0);
    measure("rgb370", 3, 7, 0);
    check("ready_back", 32'(ready_l), 32'h1);

    // Clamp: 10 and 15 saturate to always on; 9 leaves one off cycle.
    repeat (3) tick();
    send(4'd10, 4'd15, 4'd9);
    measure("clamp0", 10, 10, 9);
    measure("clamp1", 10, 10, 9);
    measure("clamp2", 10, 10, 9);

    // Back-to-back: A accepted, C ignored while stalled, B accepted after A activates.
    repeat (3) tick();
    duty_in    = {4'd6, 4'd4, 4'd2};   // A
    duty_valid = 1'b1;
    tick();
    duty_in = {4'd1, 4'd1, 4'd1};      // C, offered while stalled
    tick();
    tick();
    @(negedge clk);
    check("stall_ready", 32'(ready_l), 32'h0);
    duty_in = {4'd5, 4'd1, 4'd8};      // B
    got = 1'b0;
    for (int n = 0; n < 3 * PI; n++) begin
      if (n > 0) @(negedge clk);
      if (ready_l) begin got = 1'b1; break; end
    end
    check("b_accept_seen", 32'(got), 32'd1);
    @(posedge clk); #1;
    duty_valid = 1'b0;
    measure("set_a", 2, 4, 6);
    measure("set_b", 8, 1, 5);

    // Accept exactly on the wrap edge (count == 9).
    got = 1'b0;
    for (int n = 0; n < 3 * PI; n++) begin
      @(negedge clk);
      if (ps_l) begin got = 1'b1; break; end
    end
    check("wrap_align_seen", 32'(got), 32'd1);
    repeat (8) @(posedge clk);
    #1;
    send(4'd5, 4'd1, 4'd5);
    measure("wrap_same", 8, 1, 5);
    measure("wrap_next", 5, 1, 5);

    // Reset mid-period with a pending value and a value offered during reset.
    repeat (3) tick();
    send(4'd9, 4'd9, 4'd9);
    tick();
    rst_n      = 1'b0;
    duty_in    = {4'd7, 4'd7, 4'd7};
    duty_valid = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check("rst2_pwm_low",  32'(pwm_l),   32'h7);
    check("rst2_pwm_high", 32'(pwm_h),   32'h0);
    check("rst2_ps",       32'(ps_l),    32'h0);
    check("rst2_ready",    32'(ready_l), 32'h1);
    @(posedge clk); #1;
    rst_n      = 1'b1;
    duty_valid = 1'b0;
    measure("post_rst0", 0, 0, 0);
    measure("post_rst1", 0, 0, 0);
    repeat (3) tick();
    send(4'd3, 4'd3, 4'd3);
    measure("post_rst3", 3, 3, 3);

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog expired");
  end

endmodule
